// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter in front of the single registerFile write port.
// Each requester has its own FIFO; a round-robin grant drains one entry per cycle into registered outputs.

module regfile_write_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushValid,
  output logic             pushReady,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             doPush;
  logic             doPop;

  // Ready looks only at pre-edge occupancy: a full FIFO never accepts, even while popping.
  assign pushReady = !rst && (count < CW'(DEPTH));
  assign empty     = (count == '0);
  assign doPush    = pushValid && pushReady;
  assign doPop     = pop && !empty;
  assign headData  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      if (doPush && !doPop) begin
        count <= count + CW'(1);
      end else if (doPop && !doPush) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

module regfile_write_arbiter #(
  parameter int DEPTH         = 2,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_reg,
  input  logic [31:0] req0_data,
  input  logic        req0_float,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_reg,
  input  logic [31:0] req1_data,
  input  logic        req1_float,
  output logic [5:0]  writeReg,
  output logic [31:0] writeData,
  output logic        regWrite,
  output logic        float,
  output logic        idle
);

  typedef struct packed {
    logic        isFloat;
    logic [5:0]  regNum;
    logic [31:0] data;
  } wrEntry_t;

  localparam int EW = $bits(wrEntry_t);

  wrEntry_t push0;
  wrEntry_t push1;
  wrEntry_t head0;
  wrEntry_t head1;
  wrEntry_t headSel;
  logic     empty0;
  logic     empty1;
  logic     grant0;
  logic     grant1;
  logic     lastGrant;
  logic     suppress;

  assign push0 = {req0_float, req0_reg, req0_data};
  assign push1 = {req1_float, req1_reg, req1_data};

  regfile_write_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) fifo0 (
    .clk       (clk),
    .rst       (rst),
    .pushValid (req0_valid),
    .pushReady (req0_ready),
    .pushData  (push0),
    .pop       (grant0),
    .headData  (head0),
    .empty     (empty0)
  );

  regfile_write_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) fifo1 (
    .clk       (clk),
    .rst       (rst),
    .pushValid (req1_valid),
    .pushReady (req1_ready),
    .pushData  (push1),
    .pop       (grant1),
    .headData  (head1),
    .empty     (empty1)
  );

  // lastGrant=1 means requester 1 was served last, so requester 0 wins the next contention.
  assign grant0   = !empty0 && (empty1 || lastGrant);
  assign grant1   = !empty1 && (empty0 || !lastGrant);
  assign headSel  = grant0 ? head0 : head1;
  assign suppress = (ZERO_SUPPRESS != 0) && !headSel.isFloat && (headSel.regNum == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant <= 1'b1;
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      float     <= 1'b0;
    end else if (grant0 || grant1) begin
      lastGrant <= grant1;
      regWrite  <= !suppress;
      writeReg  <= headSel.regNum;
      writeData <= headSel.data;
      float     <= headSel.isFloat;
    end else begin
      regWrite  <= 1'b0;
    end
  end

  assign idle = empty0 && empty1 && !regWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (DEPTH=2, ZERO_SUPPRESS=1) with a small registerFile model.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

  typedef logic [38:0] ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [5:0]  req0_reg = '0;
  logic [31:0] req0_data = '0;
  logic        req0_float = 1'b0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [5:0]  req1_reg = '0;
  logic [31:0] req1_data = '0;
  logic        req1_float = 1'b0;
  logic [5:0]  writeReg;
  logic [31:0] writeData;
  logic        regWrite;
  logic        float;
  logic        idle;

  int errors = 0;
  int checks = 0;
  ent_t q0[$];
  ent_t q1[$];
  ent_t seen[$];
  int   seenCyc[$];
  int   acc1;
  int   acc1BeforeStall;

  logic [31:0] rfInt [64] = '{default: '0};
  logic [31:0] rfFp  [64] = '{default: '0};

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DEPTH(2), .ZERO_SUPPRESS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_reg   (req0_reg),
    .req0_data  (req0_data),
    .req0_float (req0_float),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_reg   (req1_reg),
    .req1_data  (req1_data),
    .req1_float (req1_float),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .regWrite   (regWrite),
    .float      (float),
    .idle       (idle)
  );

  // registerFile stand-in: commits on the edge after the write port is loaded.
  always @(posedge clk) begin
    if (regWrite) begin
      if (float) rfFp[writeReg] <= writeData;
      else       rfInt[writeReg] <= writeData;
    end
  end

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_traffic(input int budget);
    int cyc = 0;
    acc1 = 0;
    acc1BeforeStall = -1;
    seen.delete();
    seenCyc.delete();
    @(posedge clk); #1;
    while ((q0.size() > 0 || q1.size() > 0 || !idle) && cyc < budget) begin
      req0_valid = (q0.size() > 0);
      if (q0.size() > 0) {req0_float, req0_reg, req0_data} = q0[0];
      req1_valid = (q1.size() > 0);
      if (q1.size() > 0) {req1_float, req1_reg, req1_data} = q1[0];
      @(negedge clk);
      if (regWrite) begin
        seen.push_back({float, writeReg, writeData});
        seenCyc.push_back(cyc);
      end
      if (req1_valid && !req1_ready && acc1BeforeStall < 0) acc1BeforeStall = acc1;
      if (req0_valid && req0_ready) void'(q0.pop_front());
      if (req1_valid && req1_ready) begin
        void'(q1.pop_front());
        acc1++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (cyc >= budget) begin
      errors++;
      $display("FAIL traffic_timeout: still busy after %0d cycles, want idle", cyc);
    end
  endtask

  task automatic test_reset();
    int nWrites = 0;
    #1 rst = 1'b1;
    #1;
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite: got %b want 0", regWrite); end
    checks++; if ({float, writeReg, writeData} !== 39'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {float, writeReg, writeData}); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_reg = 6'd7; req0_data = 32'h77; req0_float = 1'b0;
    req1_valid = 1'b1; req1_reg = 6'd8; req1_data = 32'h88; req1_float = 1'b0;
    @(negedge clk);
    req1_valid = 1'b0;
    req0_data = 32'h79;
    @(negedge clk);
    checks++; if (regWrite !== 1'b1 || writeData !== 32'h77) begin errors++; $display("FAIL midrst_before: got regWrite=%b data=%h want 1/77", regWrite, writeData); end
    #1 rst = 1'b1;
    req0_valid = 1'b0;
    #1;
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL midrst_regWrite: got %b want 0", regWrite); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL midrst_ready: got %b want 00", {req0_ready, req1_ready}); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b want 1", idle); end
    checks++; if (writeData !== 32'd0) begin errors++; $display("FAIL midrst_writeData: got %h want 0", writeData); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b11) begin errors++; $display("FAIL postrst_ready: got %b want 11", {req0_ready, req1_ready}); end
    repeat (6) begin
      @(negedge clk);
      if (regWrite) nWrites++;
    end
    checks++; if (nWrites != 0) begin errors++; $display("FAIL postrst_writes: got %0d writes want 0", nWrites); end
    checks++; if (rfInt[7] !== 32'd0 || rfInt[8] !== 32'd0) begin errors++; $display("FAIL postrst_rf: got r7=%h r8=%h want 0/0", rfInt[7], rfInt[8]); end
  endtask

  task automatic test_single_latency();
    do_reset();
    req0_valid = 1'b1; req0_reg = 6'd1; req0_data = 32'd44; req0_float = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    checks++; if (regWrite !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL single_k: got regWrite=%b idle=%b want 0/0", regWrite, idle); end
    @(negedge clk);
    checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL single_regWrite: got %b want 1", regWrite); end
    checks++; if (writeReg !== 6'd1 || writeData !== 32'd44 || float !== 1'b0) begin errors++; $display("FAIL single_port: got reg=%0d data=%0d float=%b want 1/44/0", writeReg, writeData, float); end
    @(negedge clk);
    checks++; if (rfInt[1] !== 32'd44) begin errors++; $display("FAIL single_commit: got %0d want 44", rfInt[1]); end
    checks++; if (regWrite !== 1'b0 || idle !== 1'b1 || writeData !== 32'd44) begin errors++; $display("FAIL single_after: got regWrite=%b idle=%b data=%0d want 0/1/44", regWrite, idle, writeData); end
  endtask

  task automatic test_contention();
    ent_t exp;
    do_reset();
    q0.delete(); q1.delete();
    for (int i = 0; i < 8; i++) begin
      q0.push_back({1'b0, 6'd2, 32'd10 + 32'(i)});
      q1.push_back({1'b0, 6'd3, 32'd20 + 32'(i)});
    end
    run_traffic(80);
    checks++; if (seen.size() != 16) begin errors++; $display("FAIL contention_count: got %0d writes want 16", seen.size()); end
    for (int i = 0; i < 16 && i < seen.size(); i++) begin
      exp = (i % 2 == 0) ? {1'b0, 6'd2, 32'd10 + 32'(i / 2)} : {1'b0, 6'd3, 32'd20 + 32'(i / 2)};
      checks++; if (seen[i] !== exp) begin errors++; $display("FAIL contention_order[%0d]: got %h want %h", i, seen[i], exp); end
      checks++; if (seenCyc[i] != seenCyc[0] + i) begin errors++; $display("FAIL contention_gap[%0d]: got cycle %0d want %0d", i, seenCyc[i], seenCyc[0] + i); end
    end
  endtask

  task automatic test_backpressure();
    int expData [10] = '{100, 200, 101, 201, 102, 202, 103, 203, 104, 105};
    ent_t exp;
    do_reset();
    q0.delete(); q1.delete();
    for (int i = 0; i < 6; i++) q0.push_back({1'b0, 6'd4, 32'd100 + 32'(i)});
    for (int i = 0; i < 4; i++) q1.push_back({1'b0, 6'd5, 32'd200 + 32'(i)});
    run_traffic(80);
    checks++; if (acc1BeforeStall != 2) begin errors++; $display("FAIL bp_stall: got %0d accepts before ready=0 want 2", acc1BeforeStall); end
    checks++; if (seen.size() != 10) begin errors++; $display("FAIL bp_count: got %0d writes want 10", seen.size()); end
    for (int i = 0; i < 10 && i < seen.size(); i++) begin
      exp = {1'b0, (expData[i] >= 200) ? 6'd5 : 6'd4, 32'(expData[i])};
      checks++; if (seen[i] !== exp) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, seen[i], exp); end
    end
  endtask

  task automatic test_zero_suppress();
    do_reset();
    req0_valid = 1'b1; req0_reg = 6'd0; req0_data = 32'd5; req0_float = 1'b0;
    @(negedge clk);
    req0_data = 32'd6; req0_float = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL zero_suppressed: got regWrite=%b want 0", regWrite); end
    checks++; if (writeData !== 32'd5 || idle !== 1'b0) begin errors++; $display("FAIL zero_consumed: got data=%0d idle=%b want 5/0", writeData, idle); end
    @(negedge clk);
    checks++; if (regWrite !== 1'b1 || float !== 1'b1 || writeReg !== 6'd0 || writeData !== 32'd6) begin
      errors++; $display("FAIL zero_float: got regWrite=%b float=%b reg=%0d data=%0d want 1/1/0/6", regWrite, float, writeReg, writeData);
    end
    @(negedge clk);
    checks++; if (regWrite !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL zero_drained: got regWrite=%b idle=%b want 0/1", regWrite, idle); end
    checks++; if (rfFp[0] !== 32'd6 || rfInt[0] !== 32'd0) begin errors++; $display("FAIL zero_rf: got fp0=%0d int0=%0d want 6/0", rfFp[0], rfInt[0]); end
  endtask

  task automatic test_full_no_passthrough();
    do_reset();
    req0_valid = 1'b1; req0_reg = 6'd10; req0_data = 32'hA0; req0_float = 1'b0;
    req1_valid = 1'b1; req1_reg = 6'd11; req1_data = 32'h5A; req1_float = 1'b0;
    @(negedge clk);
    req1_valid = 1'b0;
    req0_data = 32'hB0;
    @(negedge clk);
    checks++; if (regWrite !== 1'b1 || writeData !== 32'hA0) begin errors++; $display("FAIL full_e2: got regWrite=%b data=%h want 1/a0", regWrite, writeData); end
    req0_data = 32'hC0;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL full_ready_pop: got %b want 0", req0_ready); end
    checks++; if (writeData !== 32'h5A) begin errors++; $display("FAIL full_e3: got data=%h want 5a", writeData); end
    req0_data = 32'hD0;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b want 1", req0_ready); end
    checks++; if (regWrite !== 1'b1 || writeData !== 32'hB0) begin errors++; $display("FAIL full_e4: got regWrite=%b data=%h want 1/b0", regWrite, writeData); end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++; if (regWrite !== 1'b1 || writeData !== 32'hC0) begin errors++; $display("FAIL full_e5: got regWrite=%b data=%h want 1/c0", regWrite, writeData); end
    @(negedge clk);
    checks++; if (regWrite !== 1'b1 || writeData !== 32'hD0) begin errors++; $display("FAIL full_e6: got regWrite=%b data=%h want 1/d0", regWrite, writeData); end
    @(negedge clk);
    checks++; if (regWrite !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL full_e7: got regWrite=%b idle=%b want 0/1", regWrite, idle); end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_contention();
    test_backpressure();
    test_zero_suppress();
    test_full_no_passthrough();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of registerFile (writeReg, writeData, regWrite, float) between two writeback requesters: req0 is the integer pipeline and req1 is the multi-cycle FPU/load unit.
- Each requester is buffered in its own small FIFO.
- A round-robin arbiter drains one entry per cycle into registered write-port outputs.
- The block sits between the writeback stage and registerFile.

Parameters:
- DEPTH, 2, entries per requester FIFO; power of 2, at least 2.
- ZERO_SUPPRESS, 1, when 1, integer writes to register 0 are consumed but not committed.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a write.
- req0_ready  out  1  requester 0 FIFO can accept.
- req0_reg  in  6  destination register, requester 0.
- req0_data  in  32  write data, requester 0.
- req0_float  in  1  destination is in the float bank, requester 0.
- req1_valid / req1_ready / req1_reg / req1_data / req1_float: same widths and meanings, requester 1.
- writeReg  out  6  to registerFile writeReg.
- writeData  out  32  to registerFile writeData.
- regWrite  out  1  to registerFile regWrite.
- float  out  1  to registerFile float.
- idle  out  1  both FIFOs empty and regWrite=0.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values (async, immediate): FIFOs empty, regWrite=0, writeReg=0, writeData=0, float=0, req0_ready=0, req1_ready=0, idle=1, last_grant=1 (so req0 wins first contention).
- Reset asserted mid-operation discards all buffered and in-flight writes. Nothing reaches registerFile after the reset edge.
- Ready: reqN_ready = !rst && (occupancy_N < DEPTH). It is derived from pre-edge occupancy only and never depends on reqN_valid.
- No full-FIFO pass-through: a full FIFO shows ready=0 even in a cycle where it is also being popped.
- Accept: at posedge with reqN_valid && reqN_ready, push {reg, data, float}. Inputs while ready=0 are ignored; the requester must hold them.
- Arbitration, evaluated each posedge on pre-edge FIFO state:
  - Neither FIFO non-empty: no grant.
  - Exactly one non-empty: grant it.
  - Both non-empty: grant the one not equal to last_grant.
  - On any grant: last_grant <= granted index; pop the granted head.
- Output register, same edge as the grant:
  - writeReg/writeData/float <= head fields.
  - regWrite <= 1, except ZERO_SUPPRESS=1 && head.float=0 && head.reg=0, where regWrite <= 0 (entry still popped).
  - No grant: regWrite <= 0; writeReg/writeData/float hold their last values.
- Each write-port entry drives regWrite for exactly one cycle. Maximum throughput is one write per cycle total.
- Latency:
  - Push at edge k gives grant/output load at earliest edge k+1.
  - registerFile commits at edge k+2.
  - With the other FIFO contending, commit occurs at k+3 at the latest when no other entries are queued ahead.
- Ordering: FIFO order is preserved within each requester. No ordering is guaranteed between requesters; hazard avoidance between them is the issuing control's responsibility.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1…
- Simultaneous push and pop on the same FIFO in one edge is legal when not full. Occupancy is unchanged.
- FIFO pointers wrap modulo DEPTH. Occupancy is held in log2(DEPTH)+1 bits and must never exceed DEPTH or underflow.
- idle: combinational, = both FIFOs empty && !regWrite.

Test Plan:
- Reset/idle: assert rst mid-stream with 2 entries queued → regWrite=0, both ready=0, idle=1 immediately; after deassert both ready=1 and no write ever appears for the dropped entries.
- Single write latency: req0 pushes reg=1, data=44, float=0 at edge k → regWrite=1, writeReg=1, writeData=44 during cycle after k+1; registerFile reg 1 reads 44 after edge k+2.
- Contention fairness: both valid every cycle from reset (req0 data 10,11,12…; req1 data 20,21,22…) → write port sequence 10,20,11,21,12,22, one write per cycle, no cycle with regWrite=0 once started.
- Backpressure: req1 valid for 4 consecutive cycles while req0 saturates, DEPTH=2 → req1_ready falls to 0 after 2 accepts; held data is accepted later in order with no loss or duplication.
- Zero suppression: req0 pushes reg=0, float=0, data=5, then reg=0, float=1, data=6 → first slot regWrite=0 (entry consumed); second slot regWrite=1, float=1, writeReg=0, writeData=6.
- Full-FIFO pass-through: fill req0 FIFO (2 entries) while the arbiter pops → ready stays 0 on the popping cycle and returns to 1 the following cycle.
